// File: rtl/pte_lookup_cache.sv
// pte_lookup_cache: small fully associative cache of page-table translations.
// Each lookup gets a registered response one cycle later. A fill landing in
// the same cycle is forwarded to that lookup. Fills replace entries in this
// order: an entry that already holds the tag, then a free slot, then a
// round-robin victim.
module pte_lookup_cache #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 27,
  parameter int PPN_W   = 20,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             fill_valid,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [PPN_W-1:0] fill_ppn,
  input  logic             flush,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [PPN_W-1:0] resp_ppn,
  output logic [IDX_W-1:0] resp_idx,
  output logic [IDX_W:0]   valid_count
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic [IDX_W-1:0]   victim_q;
  logic [IDX_W:0]     count_q;

  logic               fill_match;
  logic [IDX_W-1:0]   fill_match_idx;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   fill_idx;

  logic               lookup_hit;
  logic [PPN_W-1:0]   lookup_ppn;
  logic [IDX_W-1:0]   lookup_idx;

  assign valid_count = count_q;

  // Choose the fill target: an existing copy of the tag, else the lowest free slot, else the victim.
  always_comb begin
    fill_match     = 1'b0;
    fill_match_idx = '0;
    has_free       = 1'b0;
    free_idx       = '0;
    fill_idx       = victim_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == fill_tag)) begin
        fill_match     = 1'b1;
        fill_match_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    if (fill_match) begin
      fill_idx = fill_match_idx;
    end else if (has_free) begin
      fill_idx = free_idx;
    end
  end

  // Search the entries. A same-cycle fill of the same tag takes precedence over any stored copy.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    lookup_idx = '0;
    if (fill_valid && (fill_tag == lookup_tag)) begin
      lookup_hit = 1'b1;
      lookup_ppn = fill_ppn;
      lookup_idx = fill_idx;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
          lookup_hit = 1'b1;
          lookup_ppn = lookup_ppn | ppn_q[i];
          lookup_idx = lookup_idx | IDX_W'(i);
        end
      end
    end
  end

  // Maintain the valid bits, victim pointer and occupancy count. Reset and flush both override fills.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q  <= '0;
      victim_q <= '0;
      count_q  <= '0;
    end else if (fill_valid) begin
      valid_q[fill_idx] <= 1'b1;
      if (!fill_match && has_free) begin
        count_q <= count_q + (IDX_W + 1)'(1);
      end else if (!fill_match) begin
        victim_q <= victim_q + IDX_W'(1);
      end
    end
  end

  // Write tag and PPN into the target slot. This storage has no reset because valid_q guards it.
  always_ff @(posedge clk) begin
    if (!rst && !flush && fill_valid) begin
      tag_q[fill_idx] <= fill_tag;
      ppn_q[fill_idx] <= fill_ppn;
    end
  end

  // Register the lookup response. Data outputs are forced to zero unless the lookup was a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_ppn   <= '0;
      resp_idx   <= '0;
    end else begin
      resp_valid <= lookup_valid;
      resp_hit   <= lookup_valid && lookup_hit;
      resp_ppn   <= (lookup_valid && lookup_hit) ? lookup_ppn : '0;
      resp_idx   <= (lookup_valid && lookup_hit) ? lookup_idx : '0;
    end
  end

endmodule

// File: tb/tb_pte_lookup_cache.sv
// tb_pte_lookup_cache: directed, table-driven bench for pte_lookup_cache.
// Each table row describes one clock cycle of inputs. The expected outputs
// in that row are the values seen just after that cycle's rising edge.
module tb_pte_lookup_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [26:0] lookup_tag = '0;
  logic        fill_valid = 1'b0;
  logic [26:0] fill_tag = '0;
  logic [19:0] fill_ppn = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_hit;
  logic [19:0] resp_ppn;
  logic [2:0]  resp_idx;
  logic [3:0]  valid_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        lv;
    logic [26:0] lt;
    logic        fv;
    logic [26:0] ft;
    logic [19:0] fp;
    logic        ev;
    logic        eh;
    logic [19:0] ep;
    logic [2:0]  ei;
    logic [3:0]  ec;
  } vec_t;

  vec_t vecs[$];

  pte_lookup_cache dut (
    .clk(clk),
    .rst(rst),
    .lookup_valid(lookup_valid),
    .lookup_tag(lookup_tag),
    .fill_valid(fill_valid),
    .fill_tag(fill_tag),
    .fill_ppn(fill_ppn),
    .flush(flush),
    .resp_valid(resp_valid),
    .resp_hit(resp_hit),
    .resp_ppn(resp_ppn),
    .resp_idx(resp_idx),
    .valid_count(valid_count)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic add_vec(input logic r, input logic fl, input logic lv, input logic [26:0] lt,
                         input logic fv, input logic [26:0] ft, input logic [19:0] fp,
                         input logic ev, input logic eh, input logic [19:0] ep,
                         input logic [2:0] ei, input logic [3:0] ec);
    vec_t v;
    v.rst = r; v.flush = fl; v.lv = lv; v.lt = lt; v.fv = fv; v.ft = ft; v.fp = fp;
    v.ev = ev; v.eh = eh; v.ep = ep; v.ei = ei; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then sample just after the rising edge.
  task automatic apply_stimulus(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; flush = v.flush;
    lookup_valid = v.lv; lookup_tag = v.lt;
    fill_valid = v.fv; fill_tag = v.ft; fill_ppn = v.fp;
    @(posedge clk);
    #1;
    check_output({tag, " resp_valid"}, 32'(resp_valid), 32'(v.ev));
    check_output({tag, " resp_hit"}, 32'(resp_hit), 32'(v.eh));
    check_output({tag, " resp_ppn"}, 32'(resp_ppn), 32'(v.ep));
    check_output({tag, " resp_idx"}, 32'(resp_idx), 32'(v.ei));
    check_output({tag, " valid_count"}, 32'(valid_count), 32'(v.ec));
  endtask

  initial begin
    vec_t v;
    // Row arguments: rst flush lv lt fv ft fp | ev eh ep ei ec
    add_vec(1, 0, 1, 27'h1,  0, 0, 0,          0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 27'h1,  0, 0, 0,          1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0,      0, 0, 0,          0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0,      1, 27'h10, 20'hABCDE, 0, 0, 0, 0, 1);
    add_vec(0, 0, 1, 27'h10, 0, 0, 0,          1, 1, 20'hABCDE, 0, 1);
    add_vec(0, 0, 0, 0,      1, 27'h10, 20'h12345, 0, 0, 0, 0, 1);
    add_vec(0, 0, 1, 27'h10, 0, 0, 0,          1, 1, 20'h12345, 0, 1);
    add_vec(1, 0, 0, 0,      0, 0, 0,          0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 27'h20, 1, 27'h20, 20'h55, 1, 1, 20'h55, 0, 1);
    add_vec(0, 0, 1, 27'h20, 0, 0, 0,          1, 1, 20'h55, 0, 1);
    add_vec(1, 0, 0, 0,      0, 0, 0,          0, 0, 0, 0, 0);
    // Fill tags 0..7. Each row also looks up the previous tag (tag 0 is forwarded).
    add_vec(0, 0, 1, 27'h0,  1, 27'h0, 20'h100, 1, 1, 20'h100, 0, 1);
    for (int k = 1; k < 8; k++)
      add_vec(0, 0, 1, 27'(k - 1), 1, 27'(k), 20'(k + 'h100),
              1, 1, 20'(k - 1 + 'h100), 3'(k - 1), 4'(k + 1));
    add_vec(0, 0, 1, 27'h3,  1, 27'h8, 20'h999, 1, 1, 20'h103, 3, 8);
    add_vec(0, 0, 1, 27'h0,  0, 0, 0,          1, 0, 0, 0, 8);
    add_vec(0, 0, 1, 27'h8,  0, 0, 0,          1, 1, 20'h999, 0, 8);
    add_vec(0, 0, 1, 27'h9,  1, 27'h9, 20'h777, 1, 1, 20'h777, 1, 8);
    add_vec(0, 0, 1, 27'h9,  1, 27'h9, 20'h778, 1, 1, 20'h778, 1, 8);
    add_vec(0, 0, 1, 27'h2,  1, 27'hA, 20'hAAA, 1, 1, 20'h102, 2, 8);
    add_vec(0, 0, 1, 27'h2,  0, 0, 0,          1, 0, 0, 0, 8);
    add_vec(0, 0, 1, 27'hA,  0, 0, 0,          1, 1, 20'hAAA, 2, 8);
    add_vec(0, 1, 1, 27'h7,  1, 27'h30, 20'h33, 1, 1, 20'h107, 7, 0);
    add_vec(0, 0, 1, 27'h30, 0, 0, 0,          1, 0, 0, 0, 0);
    add_vec(0, 0, 1, 27'h8,  0, 0, 0,          1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0,      1, 27'h40, 20'h44, 0, 0, 0, 0, 1);
    add_vec(0, 0, 1, 27'h40, 0, 0, 0,          1, 1, 20'h44, 0, 1);
    add_vec(0, 0, 1, 27'h40, 0, 0, 0,          1, 1, 20'h44, 0, 1);
    add_vec(1, 0, 1, 27'h40, 0, 0, 0,          0, 0, 0, 0, 0);
    add_vec(0, 0, 1, 27'h40, 0, 0, 0,          1, 0, 0, 0, 0);

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int r = 0; r < vecs.size(); r++)
      apply_stimulus(vecs[r], $sformatf("row%0d", r));

    // Victim pointer wrap: fill the cache, then replace 9 times using forwarded lookups to see each index.
    for (int i = 0; i < 8; i++) begin
      v = '{rst: 0, flush: 0, lv: 0, lt: 0, fv: 1, ft: 27'(i + 'h100), fp: 20'(i),
            ev: 0, eh: 0, ep: 0, ei: 0, ec: 4'(i + 1)};
      apply_stimulus(v, $sformatf("wrapfill%0d", i));
    end
    for (int j = 0; j < 9; j++) begin
      v = '{rst: 0, flush: 0, lv: 1, lt: 27'(j + 'h200), fv: 1, ft: 27'(j + 'h200), fp: 20'(j + 'h500),
            ev: 1, eh: 1, ep: 20'(j + 'h500), ei: 3'(j % 8), ec: 8};
      apply_stimulus(v, $sformatf("victim%0d", j));
    end
    v = '{rst: 0, flush: 0, lv: 1, lt: 27'h200, fv: 0, ft: 0, fp: 0,
          ev: 1, eh: 0, ep: 0, ei: 0, ec: 8};
    apply_stimulus(v, "evicted200");
    v = '{rst: 0, flush: 0, lv: 1, lt: 27'h201, fv: 0, ft: 0, fp: 0,
          ev: 1, eh: 1, ep: 20'h501, ei: 1, ec: 8};
    apply_stimulus(v, "kept201");
    v = '{rst: 0, flush: 0, lv: 0, lt: 0, fv: 0, ft: 0, fp: 0,
          ev: 0, eh: 0, ep: 0, ei: 0, ec: 8};
    apply_stimulus(v, "idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
